// File: rtl/mul_pipe_vr_if.sv
// Valid/ready bundle for the lane-parallel multiply-accumulate pipe.
// The master drives operands and out_ready; the slave returns in_ready, out_valid and p.
interface mul_pipe_vr_if #(
    parameter int W     = 8,
    parameter int LANES = 2,
    parameter int G     = 4
);
    localparam int ACCW = 2 * W + G;

    logic                  in_valid;
    logic                  in_ready;
    logic [LANES*W-1:0]    a;
    logic [LANES*W-1:0]    b;
    logic                  signed_mode;
    logic                  acc_en;
    logic                  acc_clr;
    logic                  out_valid;
    logic                  out_ready;
    logic [LANES*ACCW-1:0] p;

    modport master (
        output in_valid, a, b, signed_mode, acc_en, acc_clr, out_ready,
        input  in_ready, out_valid, p
    );

    modport slave (
        input  in_valid, a, b, signed_mode, acc_en, acc_clr, out_ready,
        output in_ready, out_valid, p
    );
endinterface

// File: rtl/mul_pipe_vr.sv
// Per-lane signed/unsigned multiplier with optional wrap-around accumulation, LAT-cycle latency.
// A stalled output freezes the whole pipe; in_ready = !out_valid | out_ready, independent of in_valid.
module mul_pipe_vr #(
    parameter int W     = 8,
    parameter int LANES = 2,
    parameter int LAT   = 3,
    parameter int G     = 4
) (
    input  logic          CLK,
    input  logic          rst,
    mul_pipe_vr_if.slave  bus
);
    localparam int ACCW = 2 * W + G;
    localparam int PW   = 2 * W + 2;

    logic [LAT-1:0]        v;
    logic                  advance;
    logic [LANES*W-1:0]    a0;
    logic [LANES*W-1:0]    b0;
    logic                  sm0;
    logic [LAT-2:0]        en_q;
    logic [LAT-2:0]        clr_q;
    logic [LANES*ACCW-1:0] xp_c;
    logic [LANES*ACCW-1:0] xp_fin;
    logic [LANES*ACCW-1:0] sum_c;
    logic [LANES*ACCW-1:0] p_nxt;
    logic [LANES*ACCW-1:0] acc_nxt;
    logic [LANES*ACCW-1:0] p_q;
    logic [LANES*ACCW-1:0] acc_q;

    // One extra bit above W lets a single signed multiply serve both modes.
    function automatic logic [ACCW-1:0] lane_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                                 input logic sm);
        logic signed [PW-1:0] sx;
        logic signed [PW-1:0] sy;
        logic signed [PW-1:0] pr;
        sx = {{(W+2){sm & x[W-1]}}, x};
        sy = {{(W+2){sm & y[W-1]}}, y};
        pr = sx * sy;
        return ACCW'(pr);
    endfunction

    assign advance       = !v[LAT-1] | bus.out_ready;
    assign bus.in_ready  = advance;
    assign bus.out_valid = v[LAT-1];
    assign bus.p         = p_q;

    always_comb begin
        xp_c = '0;
        for (int k = 0; k < LANES; k++) begin
            xp_c[k*ACCW +: ACCW] = lane_mul(a0[k*W +: W], b0[k*W +: W], sm0);
        end
    end

    if (LAT > 2) begin : g_dly
        logic [LANES*ACCW-1:0] xp_q [LAT-2];

        always_ff @(posedge CLK) begin
            if (rst) begin
                for (int i = 0; i < LAT - 2; i++) xp_q[i] <= '0;
            end else if (advance) begin
                xp_q[0] <= xp_c;
                for (int i = 1; i < LAT - 2; i++) xp_q[i] <= xp_q[i-1];
            end
        end

        assign xp_fin = xp_q[LAT-3];
    end else begin : g_nodly
        assign xp_fin = xp_c;
    end

    // Control bits are shared by all lanes, so whole-vector muxes keep lanes independent.
    always_comb begin
        sum_c = '0;
        for (int k = 0; k < LANES; k++) begin
            sum_c[k*ACCW +: ACCW] = (clr_q[LAT-2] ? '0 : acc_q[k*ACCW +: ACCW])
                                  + xp_fin[k*ACCW +: ACCW];
        end
        p_nxt   = en_q[LAT-2] ? sum_c : xp_fin;
        acc_nxt = en_q[LAT-2] ? sum_c : (clr_q[LAT-2] ? '0 : acc_q);
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            v     <= '0;
            a0    <= '0;
            b0    <= '0;
            sm0   <= 1'b0;
            en_q  <= '0;
            clr_q <= '0;
            p_q   <= '0;
            acc_q <= '0;
        end else if (advance) begin
            v[0] <= bus.in_valid;
            for (int i = 1; i < LAT; i++) v[i] <= v[i-1];
            if (bus.in_valid) begin
                a0       <= bus.a;
                b0       <= bus.b;
                sm0      <= bus.signed_mode;
                en_q[0]  <= bus.acc_en;
                clr_q[0] <= bus.acc_clr;
            end
            for (int i = 1; i < LAT - 1; i++) begin
                en_q[i]  <= en_q[i-1];
                clr_q[i] <= clr_q[i-1];
            end
            // Only a valid transaction entering the last stage touches p and acc.
            if (v[LAT-2]) begin
                p_q   <= p_nxt;
                acc_q <= acc_nxt;
            end
        end
    end
endmodule

// File: doc/mul_pipe_vr.md
MUL_PIPE_VR -- requirements
Module: mul_pipe_vr

Interface
REQ-001 SHALL have parameter W, default 8, operand width per lane (W >= 2).
REQ-002 SHALL have parameter LANES, default 2, number of independent multiplier lanes (LANES >= 1).
REQ-003 SHALL have parameter LAT, default 3, input-to-output latency in cycles (LAT >= 2).
REQ-004 SHALL have parameter G, default 4, accumulator guard bits; ACCW = 2*W+G.
REQ-005 CLK  input  1  clock, all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 in_valid  input  1  upstream transaction present.
REQ-008 in_ready  output  1  block accepts transaction this cycle.
REQ-009 a  input  LANES*W  operand A, lane k in bits [k*W +: W].
REQ-010 b  input  LANES*W  operand B, same lane packing.
REQ-011 signed_mode  input  1  1: operands two's complement; 0: unsigned.
REQ-012 acc_en  input  1  1: lane results accumulate into per-lane accumulator.
REQ-013 acc_clr  input  1  1: accumulator cleared before this transaction's contribution.
REQ-014 out_valid  output  1  result present on p.
REQ-015 out_ready  input  1  downstream accepts result.
REQ-016 p  output  LANES*ACCW  result, lane k in bits [k*ACCW +: ACCW].

Function
REQ-017 SHALL implement LAT pipeline stages, each with a valid bit v[0..LAT-1]; out_valid = v[LAT-1].
REQ-018 SHALL define advance = !v[LAT-1] | out_ready; in_ready = advance (combinational, no dependence on in_valid).
REQ-019 SHALL accept a transaction when in_valid & in_ready; stage 0 captures a, b, signed_mode, acc_en, acc_clr.
REQ-020 SHALL, when advance=1, shift every stage forward and set v[0] = in_valid; when advance=0, hold all stages, v bits and p unchanged.
REQ-021 SHALL, with no stall, present an accepted transaction on p exactly LAT cycles after acceptance; full throughput of one transaction per cycle.
REQ-022 SHALL compute the per-lane product between stage 0 and stage 1 as a full 2W-bit product, signed or unsigned per captured signed_mode.
REQ-023 SHALL extend each product to ACCW bits: sign-extend when signed_mode=1, zero-extend when 0.
REQ-024 SHALL, when a valid transaction enters stage LAT-1: base = acc_clr ? 0 : acc[k]; sum = base + ext_product, modulo 2^ACCW (wrap, no saturation).
REQ-025 SHALL, if acc_en=1, drive lane k of p with sum and update acc[k] = sum; if acc_en=0, drive ext_product and set acc[k] = acc_clr ? 0 : acc[k].
REQ-026 SHALL update acc only on the advance cycle that loads stage LAT-1 with a valid transaction; bubbles never modify acc.
REQ-027 SHALL preserve transaction order; no transaction dropped or duplicated under any out_ready pattern.
REQ-028 SHALL treat lanes independently; lane k output depends only on lane k operands and acc[k].
REQ-029 SHALL tolerate X on a/b when the corresponding stage valid bit is 0 without corrupting acc.

Reset
REQ-030 SHALL, when rst=1 at a clock edge, clear all v bits, all data stage registers, p and every acc[k] to 0, overriding advance.
REQ-031 SHALL, after reset, present out_valid=0, p=0, in_ready=1; in-flight transactions discarded (reset mid-operation drops them).
REQ-032 SHALL ignore in_valid in the cycle rst=1.

Verification (W=8, LANES=2, LAT=3, G=4, ACCW=20)
REQ-033 Signed: lane0 a=0xFD (-3), b=0x05, signed_mode=1 -> 3 cycles later lane0 p=0xFFFF1; lane1 a=0x80,b=0x80 -> 0x04000 (16384).
REQ-034 Unsigned: same lane0 bits, signed_mode=0 -> p=0x004F1 (1265); lane1 0xFF*0xFF -> 0x0FE01.
REQ-035 Backpressure: stream 5 back-to-back inputs, hold out_ready=0 from cycle 3 for 4 cycles -> in_ready=0 while v[2]=1, p stable, all 5 results emerge in order, none lost.
REQ-036 Accumulate: 4 transactions a=b=0x7F, acc_en=1, acc_clr=1 on first only -> p=16129, 32258, 48387, 64516; fifth with acc_en=0 -> p=16129, acc remains 64516.
REQ-037 Wrap: preload acc to 0xFFFFF via accumulates, then add product 1 (a=b=1) -> p=0x00000, no flag, next accumulate continues from 0.
REQ-038 Reset mid-operation: pipe full, out_ready=0, assert rst one cycle -> next cycle out_valid=0, p=0, in_ready=1; subsequent accumulate starts from 0.
